main_control_fsm: RTL and testbench

//  Multicycle main control unit for the MIPS-subset datapath. Decodes the instruction opcode over

---
 rtl/main_control_fsm_if.sv | 45 ++++
 rtl/main_control_fsm.sv | 164 ++++++++++++++++
 tb/tb_main_control_fsm.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/main_control_fsm_if.sv
// main_control_fsm_if
//   Control bundle between the multicycle main control unit and the datapath.
//   master : the control FSM (consumes opcode/mem_ready, drives every enable,
//            mux select, the OpALU code and the debug state).
//   slave  : the datapath side (drives opcode/mem_ready, consumes controls).
//   Signals:
//     opcode[5:0]    instr[31:26] from the instruction register
//     mem_ready      memory ack (read data valid / write accepted)
//     OpALU[1:0]     00 add, 01 sub, 10 funct-decoded
//     pc_write, pc_write_cond, pc_source[1:0], iord, mem_read, mem_write,
//     ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0],
//     illegal_op, state[3:0]
interface main_control_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [1:0] OpALU;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output OpALU, pc_write, pc_write_cond, pc_source, iord, mem_read,
           mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
           alu_src_b, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  OpALU, pc_write, pc_write_cond, pc_source, iord, mem_read,
           mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
           alu_src_b, illegal_op, state
  );
endinterface

// File: rtl/main_control_fsm.sv
// main_control_fsm
//   Multicycle main control unit for the MIPS-subset datapath (R, LW, SW,
//   BEQ, ADDI, J). Moore FSM: every control output is decoded from the state
//   register; the only input path to an output is mem_ready gating the
//   PC/IR load strobes in FETCH, so each strobe fires once per instruction.
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset (forces IDLE, outputs 0)
//     bus    main_control_fsm_if.master - opcode/mem_ready in, controls out
module main_control_fsm (
  input  logic                  clk,
  input  logic                  rst_n,
  main_control_fsm_if.master    bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXEC    = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JUMP    = 4'd12,
    ILLEGAL = 4'd13
  } state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign bus.state = state_q;

  always_comb begin
    state_d           = state_q;
    bus.OpALU         = 2'b00;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_source     = 2'b00;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.illegal_op    = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        // PC+4 and IR load only on the accepted read, so a stall never
        // advances the PC twice.
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end

      DECODE: begin
        // Branch target PC + (imm<<2) is precomputed into ALUOut here.
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = ILLEGAL;
        endcase
      end

      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      end

      MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end

      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d = FETCH;
      end

      MEMWR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end

      EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.OpALU     = 2'b10;
        state_d = ALUWB;
      end

      ALUWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        state_d = FETCH;
      end

      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.OpALU         = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        state_d = FETCH;
      end

      ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d = ADDIWB;
      end

      ADDIWB: begin
        bus.reg_write = 1'b1;
        state_d = FETCH;
      end

      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        state_d = FETCH;
      end

      ILLEGAL: begin
        bus.illegal_op = 1'b1;
        state_d = FETCH;
      end

      // Encodings 14/15 are unreachable; recover through IDLE with outputs 0.
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm
//   Directed-vector bench for main_control_fsm. Each cycle drives mem_ready
//   on the falling edge, then compares the debug state and the packed control
//   word against hand-written per-state vectors.
module tb_main_control_fsm;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  main_control_fsm_if bus ();

  main_control_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed control word:
  // {OpALU[1:0], pc_write, pc_write_cond, pc_source[1:0], iord, mem_read,
  //  mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
  //  alu_src_b[1:0], illegal_op}
  function automatic logic [16:0] mk(
    input logic [1:0] opalu, input logic pcw, input logic pcwc,
    input logic [1:0] pcsrc, input logic iord, input logic mr,
    input logic mw, input logic irw, input logic rd, input logic m2r,
    input logic rw, input logic asa, input logic [1:0] asb, input logic ill);
    return {opalu, pcw, pcwc, pcsrc, iord, mr, mw, irw, rd, m2r, rw, asa, asb, ill};
  endfunction

  logic [16:0] c_zero, c_fwait, c_frdy, c_decode, c_memadr, c_memrd, c_memwb;
  logic [16:0] c_memwr, c_exec, c_aluwb, c_branch, c_addiex, c_addiwb, c_jump, c_ill;

  initial begin
    c_zero   = mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    c_fwait  = mk(2'b00, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    c_frdy   = mk(2'b00, 1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 0);
    c_decode = mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0);
    c_memadr = mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0);
    c_memrd  = mk(2'b00, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    c_memwb  = mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0);
    c_memwr  = mk(2'b00, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0);
    c_exec   = mk(2'b10, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0);
    c_aluwb  = mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0);
    c_branch = mk(2'b01, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0);
    c_addiex = mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0);
    c_addiwb = mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0);
    c_jump   = mk(2'b00, 1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    c_ill    = mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
  end

  function automatic logic [16:0] ctl_now();
    return {bus.OpALU, bus.pc_write, bus.pc_write_cond, bus.pc_source,
            bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
            bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.illegal_op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive mem_ready on the falling edge, then check the
  // state and control word that result from it.
  task automatic cyc(input string tag, input logic mr, input logic [3:0] st,
                     input logic [16:0] ctl);
    @(negedge clk);
    bus.mem_ready = mr;
    #1;
    check({tag, ".state"}, {28'd0, bus.state}, {28'd0, st});
    check({tag, ".ctl"}, {15'd0, ctl_now()}, {15'd0, ctl});
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'b000000;
    #3;
    check("rst.state", {28'd0, bus.state}, 32'd0);
    check("rst.ctl", {15'd0, ctl_now()}, {15'd0, c_zero});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel.state", {28'd0, bus.state}, 32'd0);
    check("rel.ctl", {15'd0, ctl_now()}, {15'd0, c_zero});

    // R-type
    bus.opcode = 6'b000000;
    cyc("r.fetch",  1'b1, 4'd1, c_frdy);
    cyc("r.decode", 1'b1, 4'd2, c_decode);
    cyc("r.exec",   1'b1, 4'd7, c_exec);
    cyc("r.aluwb",  1'b1, 4'd8, c_aluwb);

    // LW with 2 stall cycles in FETCH and 3 in MEMRD (10 cycles total)
    bus.opcode = 6'b100011;
    cyc("lw.fetch0", 1'b0, 4'd1, c_fwait);
    cyc("lw.fetch1", 1'b0, 4'd1, c_fwait);
    cyc("lw.fetch2", 1'b1, 4'd1, c_frdy);
    cyc("lw.decode", 1'b0, 4'd2, c_decode);
    cyc("lw.memadr", 1'b0, 4'd3, c_memadr);
    cyc("lw.memrd0", 1'b0, 4'd4, c_memrd);
    cyc("lw.memrd1", 1'b0, 4'd4, c_memrd);
    cyc("lw.memrd2", 1'b0, 4'd4, c_memrd);
    cyc("lw.memrd3", 1'b1, 4'd4, c_memrd);
    cyc("lw.memwb",  1'b0, 4'd5, c_memwb);

    // BEQ
    bus.opcode = 6'b000100;
    cyc("beq.fetch",  1'b1, 4'd1, c_frdy);
    cyc("beq.decode", 1'b1, 4'd2, c_decode);
    cyc("beq.branch", 1'b1, 4'd9, c_branch);

    // SW with one write stall
    bus.opcode = 6'b101011;
    cyc("sw.fetch",  1'b1, 4'd1, c_frdy);
    cyc("sw.decode", 1'b1, 4'd2, c_decode);
    cyc("sw.memadr", 1'b1, 4'd3, c_memadr);
    cyc("sw.memwr0", 1'b0, 4'd6, c_memwr);
    cyc("sw.memwr1", 1'b1, 4'd6, c_memwr);

    // J, mem_ready low where it must be ignored
    bus.opcode = 6'b000010;
    cyc("j.fetch",  1'b1, 4'd1,  c_frdy);
    cyc("j.decode", 1'b0, 4'd2,  c_decode);
    cyc("j.jump",   1'b0, 4'd12, c_jump);

    // ADDI
    bus.opcode = 6'b001000;
    cyc("addi.fetch",  1'b1, 4'd1,  c_frdy);
    cyc("addi.decode", 1'b1, 4'd2,  c_decode);
    cyc("addi.ex",     1'b1, 4'd10, c_addiex);
    cyc("addi.wb",     1'b1, 4'd11, c_addiwb);

    // Unsupported opcode: illegal_op for exactly one cycle
    bus.opcode = 6'b111111;
    cyc("ill.fetch",  1'b1, 4'd1,  c_frdy);
    cyc("ill.decode", 1'b1, 4'd2,  c_decode);
    cyc("ill.pulse",  1'b1, 4'd13, c_ill);
    bus.opcode = 6'b000000;
    cyc("ill.after",  1'b1, 4'd1,  c_frdy);

    // Asynchronous reset in the middle of EXEC
    cyc("ar.decode", 1'b1, 4'd2, c_decode);
    cyc("ar.exec",   1'b1, 4'd7, c_exec);
    rst_n = 1'b0;
    #1;
    check("ar.async.state", {28'd0, bus.state}, 32'd0);
    check("ar.async.ctl", {15'd0, ctl_now()}, {15'd0, c_zero});
    @(negedge clk);
    check("ar.hold.state", {28'd0, bus.state}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("ar.rel.state", {28'd0, bus.state}, 32'd0);
    cyc("ar.fetch", 1'b0, 4'd1, c_fwait);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
